bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//   Shares one simple dual-port block RAM between two bus requesters: M0 (CPU-side) and M1 (DMA/peripheral-side).
//   The RAM has a byte-strobed write port A and a read port B with 1-cycle registered read data.
//   Write port and read port are arbitrated independently, so one write and one read can complete per cycle.
//   A read that hits the word being written in the same cycle is held for 1 cycle, so it returns post-write data.
// PARAMETERS
//   ADDR_WIDTH  12  word address width; must match the RAM instance
//   RR_EN       1   1: round-robin per port; 0: fixed priority, M0 always wins
// PORTS
//   clka        in   1   clock shared with the RAM
//   rsta        in   1   synchronous, active-high reset
//   m0_req      in   1   M0 request valid; held with fields stable until m0_gnt
//   m0_we       in   1   1 = write, 0 = read
//   m0_addr     in   ADDR_WIDTH  word address
//   m0_wstrb    in   4   byte enables (write only)
//   m0_wdata    in   32  write data
//   m0_gnt      out  1   request accepted this cycle (combinational)
//   m0_rvalid   out  1   read data valid (registered)
//   m0_rdata    out  32  read data, valid when m0_rvalid
//   m1_*        --   --  same set and meaning as m0_*, for M1
//   ram_addra   out  ADDR_WIDTH  RAM write address
//   ram_dina    out  32  RAM write data
//   ram_wea     out  4   RAM byte write enables
//   ram_addrb   out  ADDR_WIDTH  RAM read address
//   ram_doutb   in   32  RAM read data, 1 cycle after ram_addrb
// BEHAVIOUR
//   Handshake
//   - A transaction is accepted when req & gnt are both high at a clka edge.
//   - After acceptance the requester may present a new request the next cycle.
//   - Each requester has at most one read in flight; a new read in the next cycle is allowed (pipelined).
//   Write path
//   - Candidates are requesters with req & we.
//   - The winner's addr/wdata/wstrb drive ram_addra/ram_dina/ram_wea in the same cycle; the RAM updates at that edge.
//   - With no winner, ram_wea = 0. wstrb = 0 is accepted and writes nothing.
//   Read path
//   - Candidates are requesters with req & ~we.
//   - The winner's addr drives ram_addrb. Next cycle that requester's rvalid = 1 and rdata = ram_doutb.
//   - With no winner, ram_addrb holds its last value and no rvalid is raised.
//   Arbitration (RR_EN = 1)
//   - Each port has a 1-bit last-winner pointer, updated only on a grant at that port.
//   - On contention the requester that is not the last winner wins; the loser holds its req.
//   Hazard
//   - Condition: a read candidate's address equals ram_addra while ram_wea != 0 in the same cycle.
//   - That read gets no grant this cycle and is re-arbitrated next cycle.
//   - The read then returns the merged post-write word.
//   - The read-port pointer does not advance for the stalled read.
//   rdata routing
//   - m*_rdata = ram_doutb (shared bus); only the rvalid of the owning requester rises.
//   - A 1-bit registered owner tag steers rvalid.
//   Reset (rsta = 1)
//   - In the reset cycle: gnt = 0 and ram_wea = 0; both pointers reset so M0 wins first contention; rvalid/owner cleared.
//   - Next cycle: both rvalid = 0.
//   - A read granted the cycle before reset produces no rvalid.
//   Latency
//   - Write: 0 cycles to grant; RAM updated at the accepting edge.
//   - Read: rvalid 1 cycle after acceptance, +1 if hazard-stalled, + contention wait.
// TESTING
//   1) M0 write addr 0x010, data 0xA5A5_1234, wstrb 0xF; then read 0x010 -> m0_gnt same cycle, m0_rvalid next cycle, rdata 0xA5A5_1234
//   2) M0 and M1 both read every cycle, RR_EN=1 -> grants alternate M0,M1,M0,...; rvalid goes only to the grantee; RR_EN=0 -> M1 never granted
//   3) Same cycle: M0 writes 0x020 = 0x1111_2222, wstrb 0x3, old word 0xFFFF_FFFF; M1 reads 0x020 -> M1 stalled 1 cycle, rdata 0xFFFF_2222
//   4) Same cycle: M0 write 0x030, M1 read 0x031 -> both granted, no stall
//   5) M1 read granted, rsta asserted next cycle -> m1_rvalid stays 0; after reset, contention grants M0 first
//   6) M0 write with wstrb 0x0 -> m0_gnt = 1, ram_wea = 0, memory unchanged, no hazard stall on a same-address read

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus bundle for bram_port_arbiter.
// One instance per requester (M0 CPU-side, M1 DMA/peripheral-side).
//   req    : request valid, held with fields stable until gnt
//   we     : 1 = write, 0 = read
//   addr   : word address
//   wstrb  : byte enables (writes only)
//   wdata  : write data
//   gnt    : request accepted this cycle (combinational)
//   rvalid : read data valid (registered)
//   rdata  : read data, valid when rvalid
// master = requester side, slave = arbiter side.
interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12
) ();
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            wstrb;
  logic [31:0]           wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (
    output req, we, addr, wstrb, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wstrb, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one simple dual-port block RAM (byte-strobed write port A, read port
// B with 1-cycle registered read data) between two requesters M0 and M1.
// The write and read ports are arbitrated independently, so one write and one
// read can complete in the same cycle. A read that targets the word being
// written in the same cycle is held off one cycle so it returns post-write data.
// Ports:
//   clka       : clock shared with the RAM
//   rsta       : synchronous active-high reset
//   m0, m1     : requester buses (bram_port_arbiter_if, slave side)
//   ram_addra  : RAM write address
//   ram_dina   : RAM write data
//   ram_wea    : RAM byte write enables
//   ram_addrb  : RAM read address
//   ram_doutb  : RAM read data, 1 cycle after ram_addrb
// Parameters:
//   ADDR_WIDTH : word address width, must match the RAM and the interfaces
//   RR_EN      : 1 = round-robin per port, 0 = fixed priority with M0 winning
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter bit RR_EN      = 1'b1
) (
  input  logic                  clka,
  input  logic                  rsta,
  bram_port_arbiter_if.slave    m0,
  bram_port_arbiter_if.slave    m1,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  typedef enum logic {
    SEL_M0 = 1'b0,
    SEL_M1 = 1'b1
  } sel_t;

  // Last-winner pointers per port and the owner tag of the read in flight.
  sel_t                  wr_last;
  sel_t                  rd_last;
  sel_t                  rd_owner;
  logic                  rd_inflight;
  logic [ADDR_WIDTH-1:0] addrb_q;

  logic wr_c0, wr_c1, wr_g0, wr_g1;
  logic wr_active;
  logic rd_c0, rd_c1, rd_g0, rd_g1;

  // Write port arbitration.
  always_comb begin
    wr_c0 = m0.req & m0.we & ~rsta;
    wr_c1 = m1.req & m1.we & ~rsta;
    // M1 wins only when alone or, in round-robin mode, when M0 won last time.
    wr_g1 = wr_c1 & (~wr_c0 | (RR_EN && (wr_last == SEL_M0)));
    wr_g0 = wr_c0 & ~wr_g1;
  end

  always_comb begin
    ram_addra = m0.addr;
    ram_dina  = m0.wdata;
    ram_wea   = '0;
    if (wr_g1) begin
      ram_addra = m1.addr;
      ram_dina  = m1.wdata;
      ram_wea   = m1.wstrb;
    end else if (wr_g0) begin
      ram_wea   = m0.wstrb;
    end
  end

  // A zero-strobe write is accepted but touches nothing, so it causes no hazard.
  assign wr_active = |ram_wea;

  // Read port arbitration; a read hitting the word being written this cycle
  // drops out of candidacy so it is re-arbitrated after the RAM has updated.
  always_comb begin
    rd_c0 = m0.req & ~m0.we & ~rsta & ~(wr_active & (m0.addr == ram_addra));
    rd_c1 = m1.req & ~m1.we & ~rsta & ~(wr_active & (m1.addr == ram_addra));
    rd_g1 = rd_c1 & (~rd_c0 | (RR_EN && (rd_last == SEL_M0)));
    rd_g0 = rd_c0 & ~rd_g1;
  end

  always_comb begin
    ram_addrb = addrb_q;
    if (rd_g1) begin
      ram_addrb = m1.addr;
    end else if (rd_g0) begin
      ram_addrb = m0.addr;
    end
  end

  // Grants, read-valid steering and shared read data.
  always_comb begin
    m0.gnt    = wr_g0 | rd_g0;
    m1.gnt    = wr_g1 | rd_g1;
    // Masked by rsta so a read accepted just before reset never reports.
    m0.rvalid = rd_inflight & (rd_owner == SEL_M0) & ~rsta;
    m1.rvalid = rd_inflight & (rd_owner == SEL_M1) & ~rsta;
    m0.rdata  = ram_doutb;
    m1.rdata  = ram_doutb;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      // Pointing at M1 makes M0 win the first contention on either port.
      wr_last     <= SEL_M1;
      rd_last     <= SEL_M1;
      rd_owner    <= SEL_M0;
      rd_inflight <= 1'b0;
      addrb_q     <= '0;
    end else begin
      if (wr_g1) begin
        wr_last <= SEL_M1;
      end else if (wr_g0) begin
        wr_last <= SEL_M0;
      end

      if (rd_g1) begin
        rd_last  <= SEL_M1;
        rd_owner <= SEL_M1;
      end else if (rd_g0) begin
        rd_last  <= SEL_M0;
        rd_owner <= SEL_M0;
      end

      rd_inflight <= rd_g0 | rd_g1;
      addrb_q     <= ram_addrb;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level model (winner selection rules plus a reference memory).
module tb_bram_port_arbiter;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) i0 ();
  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) i1 ();
  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) f0 ();
  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) f1 ();

  logic [AW-1:0] ram_addra, ram_addrb;
  logic [31:0]   ram_dina, ram_doutb;
  logic [3:0]    ram_wea;
  logic [AW-1:0] f_addra, f_addrb;
  logic [31:0]   f_dina;
  logic [3:0]    f_wea;
  logic [31:0]   f_doutb;
  assign f_doutb = 32'h0;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .RR_EN(1'b1)) dut (
    .clka(clk), .rsta(rst), .m0(i0), .m1(i1),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  bram_port_arbiter #(.ADDR_WIDTH(AW), .RR_EN(1'b0)) dut_fp (
    .clka(clk), .rsta(rst), .m0(f0), .m1(f1),
    .ram_addra(f_addra), .ram_dina(f_dina), .ram_wea(f_wea),
    .ram_addrb(f_addrb), .ram_doutb(f_doutb)
  );

  // RAM attached to the main DUT: read-before-write, registered read data.
  logic [31:0] ram    [0:4095];
  logic [31:0] refmem [0:4095];

  always @(posedge clk) begin : ram_model
    logic [31:0] t;
    ram_doutb <= ram[ram_addrb];
    if (ram_wea != 4'h0) begin
      t = ram[ram_addra];
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) t[8*b +: 8] = ram_dina[8*b +: 8];
      ram[ram_addra] = t;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            wlast = 1, rlast = 1, pend_owner = -1;
  logic [31:0]   pend_rdata = '0;
  logic [AW-1:0] last_addrb = '0;
  bit            addrb_known = 1'b0;
  bit            gnt_seen [2];

  // Winner among two candidates: a lone candidate wins; on contention the one
  // that did not win last time wins.
  function automatic int pick(input bit c0, input bit c1, input int last);
    if (c0 && c1) return (last == 0) ? 1 : 0;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  bit            rq [2], wq [2];
  logic [AW-1:0] ad [2];
  logic [3:0]    sb [2];
  logic [31:0]   wd [2];

  initial begin : compare
    int            wwin, rwin;
    logic [3:0]    ewea;
    logic [AW-1:0] waddr;
    logic [31:0]   t;
    bit            rc [2];
    bit            eg [2];
    bit            ev [2];
    gnt_seen[0] = 1'b0;
    gnt_seen[1] = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      rq[0] = i0.req; wq[0] = i0.we; ad[0] = i0.addr; sb[0] = i0.wstrb; wd[0] = i0.wdata;
      rq[1] = i1.req; wq[1] = i1.we; ad[1] = i1.addr; sb[1] = i1.wstrb; wd[1] = i1.wdata;
      wwin = -1; rwin = -1; ewea = 4'h0; waddr = '0;
      rc[0] = 1'b0; rc[1] = 1'b0;
      if (!rst) begin
        wwin = pick(rq[0] && wq[0], rq[1] && wq[1], wlast);
        if (wwin >= 0) begin
          ewea  = sb[wwin];
          waddr = ad[wwin];
        end
        for (int i = 0; i < 2; i++)
          rc[i] = rq[i] && !wq[i] && !(ewea != 4'h0 && ad[i] == waddr);
        rwin = pick(rc[0], rc[1], rlast);
      end
      for (int i = 0; i < 2; i++) begin
        eg[i] = (wwin == i) || (rwin == i);
        ev[i] = (pend_owner == i) && !rst;
      end

      check("m0_gnt", i0.gnt, eg[0]);
      check("m1_gnt", i1.gnt, eg[1]);
      check("ram_wea", ram_wea, ewea);
      if (ewea != 4'h0) begin
        check("ram_addra", ram_addra, waddr);
        check("ram_dina", ram_dina, wd[wwin]);
      end
      if (rwin >= 0) check("ram_addrb", ram_addrb, ad[rwin]);
      else if (addrb_known) check("ram_addrb_hold", ram_addrb, last_addrb);
      check("m0_rvalid", i0.rvalid, ev[0]);
      check("m1_rvalid", i1.rvalid, ev[1]);
      if (ev[0]) check("m0_rdata", i0.rdata, pend_rdata);
      if (ev[1]) check("m1_rdata", i1.rdata, pend_rdata);

      // State as it will be after the coming clock edge.
      if (rst) begin
        wlast = 1; rlast = 1; pend_owner = -1; addrb_known = 1'b0;
      end else begin
        pend_owner = rwin;
        if (rwin >= 0) begin
          pend_rdata  = refmem[ad[rwin]];
          rlast       = rwin;
          last_addrb  = ad[rwin];
          addrb_known = 1'b1;
        end
        if (wwin >= 0) begin
          wlast = wwin;
          t = refmem[waddr];
          for (int b = 0; b < 4; b++)
            if (ewea[b]) t[8*b +: 8] = wd[wwin][8*b +: 8];
          refmem[waddr] = t;
        end
      end
      gnt_seen[0] = eg[0];
      gnt_seen[1] = eg[1];
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input int i, input bit r, input bit w, input int a,
                     input logic [3:0] s, input logic [31:0] d);
    logic [AW-1:0] aa;
    aa = a[AW-1:0];
    if (i == 0) begin
      i0.req = r; i0.we = w; i0.addr = aa; i0.wstrb = s; i0.wdata = d;
    end else begin
      i1.req = r; i1.we = w; i1.addr = aa; i1.wstrb = s; i1.wdata = d;
    end
  endtask

  task automatic idle();
    drv(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
  endtask

  task automatic fdrv(input bit r);
    f0.req = r; f0.we = 1'b0; f0.addr = 12'h070; f0.wstrb = 4'h0; f0.wdata = 32'h0;
    f1.req = r; f1.we = 1'b0; f1.addr = 12'h071; f1.wstrb = 4'h0; f1.wdata = 32'h0;
  endtask

  bit cur [2];

  initial begin : stim
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = i * 32'h9E37_79B1;
      refmem[i] = i * 32'h9E37_79B1;
    end
    ram[12'h020] = 32'hFFFF_FFFF; refmem[12'h020] = 32'hFFFF_FFFF;
    ram[12'h040] = 32'h1234_5678; refmem[12'h040] = 32'h1234_5678;
    idle();
    fdrv(1'b0);
    rst = 1'b1;

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("reset_m0_rvalid", i0.rvalid, 1'b0);
    check("reset_m1_rvalid", i1.rvalid, 1'b0);

    // Write then read back at 0x010.
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 12'h010, 4'hF, 32'hA5A5_1234);
    #3;
    check("t1_wr_gnt", i0.gnt, 1'b1);
    check("t1_wea", ram_wea, 4'hF);
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
    #3;
    check("t1_rd_gnt", i0.gnt, 1'b1);
    @(negedge clk);
    idle();
    #3;
    check("t1_rvalid", i0.rvalid, 1'b1);
    check("t1_rdata", i0.rdata, 32'hA5A5_1234);
    check("t1_m1_rvalid", i1.rvalid, 1'b0);

    // Same-word write/read hazard with partial strobe.
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 12'h020, 4'h3, 32'h1111_2222);
    drv(1, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
    #3;
    check("t3_m0_gnt", i0.gnt, 1'b1);
    check("t3_m1_stall", i1.gnt, 1'b0);
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    #3;
    check("t3_m1_gnt", i1.gnt, 1'b1);
    @(negedge clk);
    idle();
    #3;
    check("t3_rvalid", i1.rvalid, 1'b1);
    check("t3_rdata", i1.rdata, 32'hFFFF_2222);

    // Different addresses: write and read both granted.
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 12'h030, 4'hF, 32'hCAFE_F00D);
    drv(1, 1'b1, 1'b0, 12'h031, 4'h0, 32'h0);
    #3;
    check("t4_m0_gnt", i0.gnt, 1'b1);
    check("t4_m1_gnt", i1.gnt, 1'b1);
    @(negedge clk);
    idle();
    #3;
    check("t4_rvalid", i1.rvalid, 1'b1);

    // Zero-strobe write: accepted, writes nothing, no hazard.
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 12'h040, 4'h0, 32'hDEAD_BEEF);
    drv(1, 1'b1, 1'b0, 12'h040, 4'h0, 32'h0);
    #3;
    check("t6_m0_gnt", i0.gnt, 1'b1);
    check("t6_wea", ram_wea, 4'h0);
    check("t6_m1_gnt", i1.gnt, 1'b1);
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    #3;
    check("t6_rdata0", i1.rdata, 32'h1234_5678);
    check("t6_rvalid1", i1.rvalid, 1'b1);
    @(negedge clk);
    idle();
    #3;
    check("t6_rdata1", i1.rdata, 32'h1234_5678);

    // Read accepted right before reset never reports.
    @(negedge clk);
    drv(1, 1'b1, 1'b0, 12'h050, 4'h0, 32'h0);
    #3;
    check("t5_m1_gnt", i1.gnt, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drv(1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    drv(0, 1'b1, 1'b1, 12'h060, 4'hF, 32'h7777_7777);
    #3;
    check("t5_rst_gnt", i0.gnt, 1'b0);
    check("t5_rst_wea", ram_wea, 4'h0);
    check("t5_rst_rvalid", i1.rvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #3;
    check("t5_post_rv0", i0.rvalid, 1'b0);
    check("t5_post_rv1", i1.rvalid, 1'b0);

    // Continuous read contention: RR alternates from M0, fixed priority starves M1.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drv(0, 1'b1, 1'b0, 12'h070, 4'h0, 32'h0);
      drv(1, 1'b1, 1'b0, 12'h071, 4'h0, 32'h0);
      fdrv(1'b1);
      #3;
      check("t2_m0_gnt", i0.gnt, (k % 2) == 0);
      check("t2_m1_gnt", i1.gnt, (k % 2) == 1);
      check("t2_fp_m0_gnt", f0.gnt, 1'b1);
      check("t2_fp_m1_gnt", f1.gnt, 1'b0);
      check("t2_fp_addrb", f_addrb, 12'h070);
      check("t2_fp_wea", f_wea, 4'h0);
      if (k > 0) begin
        check("t2_m0_rvalid", i0.rvalid, (k % 2) == 1);
        check("t2_m1_rvalid", i1.rvalid, (k % 2) == 0);
        check("t2_fp_m0_rvalid", f0.rvalid, 1'b1);
        check("t2_fp_m1_rvalid", f1.rvalid, 1'b0);
      end
    end
    @(negedge clk);
    idle();
    fdrv(1'b0);
    #3;
    check("t2_last_rvalid", i1.rvalid, 1'b1);

    // Randomized traffic on a few shared addresses to provoke contention and hazards.
    cur[0] = 1'b0;
    cur[1] = 1'b0;
    @(negedge clk);
    repeat (3000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!cur[i] || gnt_seen[i]) begin
          cur[i] = ($urandom_range(0, 9) < 7);
          drv(i, cur[i], 1'($urandom_range(0, 1)), 32'h100 + $urandom_range(0, 3),
              4'($urandom_range(0, 15)), $urandom);
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
